// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, access-size codes and lane/byte-enable helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic is_byte(input logic [2:0] f3);
    return f3 == F3_B || f3 == F3_BU;
  endfunction
  function automatic logic is_half(input logic [2:0] f3);
    return f3 == F3_H || f3 == F3_HU;
  endfunction
  // Offsets are truncated to the natural size so misaligned H/W accesses land on an aligned lane group
  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] a);
    return is_byte(f3) ? a : is_half(f3) ? {a[1], 1'b0} : 2'b00;
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return is_byte(f3) ? 1'b0 : is_half(f3) ? a[0] : a != 2'b00;
  endfunction
  // Offset o lives in the most significant lanes first, so it maps to be bit 3-o
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] o);
    return is_byte(f3) ? 4'b1000 >> o : is_half(f3) ? (o[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  endfunction
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    return is_byte(f3) ? {4{d[7:0]}} : is_half(f3) ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword out of a read word and sign- or zero-extends it
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;
  assign b  = rdata[{~offset, 3'b000} +: 8];
  assign h  = rdata[{~offset[1], 4'b0000} +: 16];
  assign sx = ~funct3[2];
  // Extend the selected lanes; anything that is neither byte nor halfword passes the word through
  always_comb data = is_byte(funct3) ? {{24{sx & b[7]}}, b} :
                     is_half(funct3) ? {{16{sx & h[15]}}, h} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage req/gnt/rvalid initiator with sizing, byte enables and stall; LSU_MISALIGN_EXC_EN enables misalignment exceptions
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              lsu_stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign_exc,
  output logic [ADDR_W-1:0] exc_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);
  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        op;
  logic        mis;
  logic [31:0] ld_data;
  assign op = ex_valid & (ex_mem_read | ex_mem_write);
`ifdef LSU_MISALIGN_EXC_EN
  assign mis = misaligned(ex_funct3, ex_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  // Stall is gated by reset so every output reads 0 while reset is held
  always_comb lsu_stall = rst & ((state == IDLE & op) | state == REQ | state == WAIT);
  load_align u_align (
    .rdata (dmem_rdata),
    .offset(off_q),
    .funct3(f3_q),
    .data  (ld_data)
  );
  // Access sequencer: capture in IDLE, hold the request until granted, wait for load data, report for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      f3_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_exc <= 1'b0;
      exc_addr     <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: if (op) begin
          f3_q  <= ex_funct3;
          off_q <= eff_off(ex_funct3, ex_addr[1:0]);
          rd_q  <= ex_rd;
          if (mis) begin
            state        <= DONE;
            misalign_exc <= 1'b1;
            exc_addr     <= ex_addr;
          end else begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= ~ex_mem_read;
            dmem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
            dmem_be    <= store_be(ex_funct3, eff_off(ex_funct3, ex_addr[1:0]));
            dmem_wdata <= store_data(ex_funct3, ex_wdata);
          end
        end
        REQ: if (dmem_gnt) begin
          dmem_req <= 1'b0;
          state    <= dmem_we ? DONE : WAIT;
        end
        WAIT: if (dmem_rvalid) begin
          state    <= DONE;
          wb_valid <= 1'b1;
          wb_rd    <= rd_q;
          wb_data  <= ld_data;
        end
        DONE: begin
          state        <= IDLE;
          wb_valid     <= 1'b0;
          misalign_exc <= 1'b0;
          exc_addr     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven vectors with a write-back scoreboard plus reset and no-op sequences
module tb_load_store_unit;
  logic        clk = 0;
  logic        rst = 0;
  logic        ex_valid = 0, ex_mem_read = 0, ex_mem_write = 0;
  logic [2:0]  ex_funct3 = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0;
  logic [4:0]  ex_rd = 0;
  logic        lsu_stall, wb_valid, misalign_exc, dmem_req, dmem_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .lsu_stall(lsu_stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign_exc(misalign_exc), .exc_addr(exc_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd_op, wr_op;
    logic [2:0] f3;
    logic [31:0] addr, wdata;
    logic [4:0] rd;
    logic [31:0] rdata;
    int gnt_dly, rv_dly;
    logic rv_in_gnt;
    logic [31:0] exp_addr;
    logic [3:0] exp_be;
    logic [31:0] exp_wdata, exp_wb;
    int exp_stall;
    logic mis;
  } vec_t;

  vec_t vecs[15];
  logic [36:0] wb_q[$];
  int vec_cnt = 0;
  int miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every wb_valid cycle must consume exactly one expected load result
  always @(negedge clk) begin
    if (wb_valid) begin
      if (wb_q.size() == 0) chk("unexpected wb_valid", 32'd1, 32'd0);
      else begin
        logic [36:0] e;
        e = wb_q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  task automatic run_vec(input int i, input vec_t v);
    int req_cyc, post, stalls;
    bit granted, saw_req, fin;
    logic is_ld;
    is_ld = v.rd_op;
    @(negedge clk);
    ex_valid = 1; ex_mem_read = v.rd_op; ex_mem_write = v.wr_op;
    ex_funct3 = v.f3; ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
    if (is_ld && !v.mis) wb_q.push_back({v.rd, v.exp_wb});
    req_cyc = 0; post = 0; stalls = 0; granted = 0; saw_req = 0; fin = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!lsu_stall) begin fin = 1; break; end
      stalls++;
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 32'hDEADBEEF;
      if (dmem_req && !granted) begin
        saw_req = 1;
        chk($sformatf("v%0d addr", i), dmem_addr, v.exp_addr);
        chk($sformatf("v%0d we", i), {31'd0, dmem_we}, {31'd0, ~is_ld});
        if (!is_ld) begin
          chk($sformatf("v%0d be", i), {28'd0, dmem_be}, {28'd0, v.exp_be});
          chk($sformatf("v%0d wdata", i), dmem_wdata, v.exp_wdata);
        end
        if (req_cyc == v.gnt_dly) begin
          dmem_gnt = 1; granted = 1; dmem_rvalid = v.rv_in_gnt;
        end
        req_cyc++;
      end else if (granted) begin
        post++;
        if (post == v.rv_dly) begin dmem_rvalid = 1; dmem_rdata = v.rdata; end
      end
      @(negedge clk);
    end
    if (!fin) chk($sformatf("v%0d timeout", i), 32'd1, 32'd0);
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
    dmem_gnt = 0; dmem_rvalid = 0;
    chk($sformatf("v%0d stall cycles", i), stalls, v.exp_stall);
    chk($sformatf("v%0d saw req", i), {31'd0, saw_req}, {31'd0, ~v.mis});
    chk($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, is_ld & ~v.mis});
    chk($sformatf("v%0d misalign_exc", i), {31'd0, misalign_exc}, {31'd0, v.mis});
    if (v.mis) chk($sformatf("v%0d exc_addr", i), exc_addr, v.addr);
    @(negedge clk);
    chk($sformatf("v%0d wb_valid drop", i), {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rd wr f3      addr       wdata         rd     rdata         g  rv ig  exp_addr   be       exp_wdata     exp_wb        st mis
    vecs[0]  = '{0, 1, 3'b010, 32'h10,  32'hAABBCCDD, 5'd0,  32'h0,        0, 0, 0, 32'h10,  4'b1111, 32'hAABBCCDD, 32'h0,        2, 0};
    vecs[1]  = '{0, 1, 3'b000, 32'h13,  32'h000000F0, 5'd0,  32'h0,        0, 0, 0, 32'h10,  4'b0001, 32'hF0F0F0F0, 32'h0,        2, 0};
    vecs[2]  = '{0, 1, 3'b001, 32'h12,  32'h1234ABCD, 5'd0,  32'h0,        0, 0, 0, 32'h10,  4'b0011, 32'hABCDABCD, 32'h0,        2, 0};
    vecs[3]  = '{0, 1, 3'b001, 32'h10,  32'h1234ABCD, 5'd0,  32'h0,        0, 0, 0, 32'h10,  4'b1100, 32'hABCDABCD, 32'h0,        2, 0};
    vecs[4]  = '{1, 0, 3'b000, 32'h01,  32'h0,        5'd5,  32'h12803456, 0, 2, 0, 32'h00,  4'b0000, 32'h0,        32'hFFFFFF80, 4, 0};
    vecs[5]  = '{1, 0, 3'b100, 32'h01,  32'h0,        5'd6,  32'h12803456, 0, 1, 0, 32'h00,  4'b0000, 32'h0,        32'h00000080, 3, 0};
    vecs[6]  = '{1, 0, 3'b001, 32'h02,  32'h0,        5'd7,  32'h12809456, 0, 1, 0, 32'h00,  4'b0000, 32'h0,        32'hFFFF9456, 3, 0};
    vecs[7]  = '{1, 0, 3'b101, 32'h100, 32'h0,        5'd0,  32'h80001234, 0, 1, 0, 32'h100, 4'b0000, 32'h0,        32'h00008000, 3, 0};
    vecs[8]  = '{1, 0, 3'b010, 32'h20,  32'h0,        5'd31, 32'hCAFEBABE, 5, 1, 0, 32'h20,  4'b0000, 32'h0,        32'hCAFEBABE, 8, 0};
    vecs[9]  = '{0, 1, 3'b010, 32'h24,  32'h01020304, 5'd0,  32'h0,        5, 0, 0, 32'h24,  4'b1111, 32'h01020304, 32'h0,        7, 0};
    vecs[10] = '{1, 0, 3'b000, 32'h03,  32'h0,        5'd3,  32'h123456F7, 0, 1, 1, 32'h00,  4'b0000, 32'h0,        32'hFFFFFFF7, 3, 0};
`ifdef LSU_MISALIGN_EXC_EN
    vecs[11] = '{1, 0, 3'b010, 32'h06,  32'h0,        5'd4,  32'h11223344, 0, 1, 0, 32'h00,  4'b0000, 32'h0,        32'h0,        1, 1};
`else
    vecs[11] = '{1, 0, 3'b010, 32'h06,  32'h0,        5'd4,  32'h11223344, 0, 1, 0, 32'h04,  4'b0000, 32'h0,        32'h11223344, 3, 0};
`endif
    vecs[12] = '{0, 1, 3'b011, 32'h30,  32'h55667788, 5'd0,  32'h0,        1, 0, 0, 32'h30,  4'b1111, 32'h55667788, 32'h0,        3, 0};
    vecs[13] = '{1, 1, 3'b010, 32'h50,  32'h99999999, 5'd12, 32'h0BADF00D, 0, 3, 0, 32'h50,  4'b0000, 32'h0,        32'h0BADF00D, 5, 0};
    vecs[14] = '{0, 1, 3'b000, 32'h14,  32'h0000003C, 5'd0,  32'h0,        0, 0, 0, 32'h14,  4'b1000, 32'h3C3C3C3C, 32'h0,        2, 0};

    ex_valid = 1; ex_mem_read = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset lsu_stall", {31'd0, lsu_stall}, 32'd0);
    chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset misalign_exc", {31'd0, misalign_exc}, 32'd0);
    chk("reset dmem_be", {28'd0, dmem_be}, 32'd0);
    ex_valid = 0; ex_mem_read = 0;
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // ex_valid without a memory op must neither stall nor request
    @(negedge clk);
    ex_valid = 1;
    #1;
    chk("noop stall", {31'd0, lsu_stall}, 32'd0);
    repeat (2) @(negedge clk);
    chk("noop dmem_req", {31'd0, dmem_req}, 32'd0);
    ex_valid = 0;

    // Reset while waiting for load data abandons the access
    @(negedge clk);
    ex_valid = 1; ex_mem_read = 1; ex_funct3 = 3'b010; ex_addr = 32'h40; ex_rd = 5'd9;
    @(negedge clk);
    #1 chk("rst seq req", {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    #1 chk("rst seq waiting", {31'd0, lsu_stall}, 32'd1);
    rst = 0;
    #1;
    chk("rst mid dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst mid stall", {31'd0, lsu_stall}, 32'd0);
    @(negedge clk);
    ex_valid = 0; ex_mem_read = 0;
    rst = 1;
    dmem_rvalid = 1; dmem_rdata = 32'h77777777;
    @(negedge clk);
    dmem_rvalid = 0;
    repeat (2) @(negedge clk);
    chk("post rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("post rst idle", {31'd0, lsu_stall | dmem_req}, 32'd0);
    run_vec(15, vecs[5]);

    repeat (2) @(negedge clk);
    chk("scoreboard empty", wb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
    $finish;
  end
endmodule
